// File: rtl/conv_line_feeder_if.sv
// conv_line_feeder_if
//   Pixel-stream bundle between a raster pixel source and the line feeder.
//   Ports (all in the clk domain of the connected modules):
//     i_valid      source -> feeder  pixel accepted this cycle
//     i_sof        source -> feeder  start of frame, qualified by i_valid
//     i_pixel      source -> feeder  signed raster-order pixel
//     o_data1..3   feeder -> sink    column of rows r-2, r-1, r
//     o_en_conv    feeder -> sink    column valid (convolver shift enable)
//     o_win_valid  feeder -> sink    column completes a full 3x3 window
//     o_eof        feeder -> sink    pulse with the last column of the frame
interface conv_line_feeder_if #(
  parameter int NB_PIXEL = 8
);
  logic                       i_valid;
  logic                       i_sof;
  logic signed [NB_PIXEL-1:0] i_pixel;
  logic signed [NB_PIXEL-1:0] o_data1;
  logic signed [NB_PIXEL-1:0] o_data2;
  logic signed [NB_PIXEL-1:0] o_data3;
  logic                       o_en_conv;
  logic                       o_win_valid;
  logic                       o_eof;

  // Source side: drives the pixel stream, observes the feeder outputs.
  modport master (
    output i_valid, i_sof, i_pixel,
    input  o_data1, o_data2, o_data3, o_en_conv, o_win_valid, o_eof
  );

  // Feeder side.
  modport slave (
    input  i_valid, i_sof, i_pixel,
    output o_data1, o_data2, o_data3, o_en_conv, o_win_valid, o_eof
  );
endinterface

// File: rtl/conv_line_feeder.sv
// conv_line_feeder
//   Turns a raster pixel stream into vertical 3-pixel columns for a 3x3
//   convolver. Two line buffers hold the previous two rows; every accepted
//   pixel pushes the column down (LB_A -> LB_B, pixel -> LB_A) and presents
//   rows r-2, r-1, r one cycle later.
//   Ports:
//     clk     single clock
//     i_nrst  synchronous active-low reset
//     bus     conv_line_feeder_if.slave (pixel stream in, columns out)
module conv_line_feeder #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int NB_PIXEL   = 8
) (
  input  logic               clk,
  input  logic               i_nrst,
  conv_line_feeder_if.slave  bus
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic [CW-1:0] col_cur;
  logic [RW-1:0] row_cur;
  logic [CW-1:0] col_next;
  logic [RW-1:0] row_next;
  logic          last_col;
  logic          last_row;
  logic          fill_rows;

  logic signed [NB_PIXEL-1:0] lb_a [IMG_WIDTH];
  logic signed [NB_PIXEL-1:0] lb_b [IMG_WIDTH];

  logic signed [NB_PIXEL-1:0] data1_reg;
  logic signed [NB_PIXEL-1:0] data2_reg;
  logic signed [NB_PIXEL-1:0] data3_reg;
  logic                       en_conv_reg;
  logic                       win_valid_reg;
  logic                       eof_reg;

  // A start-of-frame pixel is treated as (0,0) whatever the counters hold,
  // so all position decisions this cycle use the sof-adjusted position.
  always_comb begin
    col_cur   = bus.i_sof ? '0 : col_reg;
    row_cur   = bus.i_sof ? '0 : row_reg;
    last_col  = (32'(col_cur) == IMG_WIDTH - 1);
    last_row  = (32'(row_cur) == IMG_HEIGHT - 1);
    fill_rows = (32'(row_cur) < 2);
    col_next  = col_cur + CW'(1);
    row_next  = row_cur;
    if (last_col) begin
      col_next = '0;
      row_next = last_row ? '0 : row_cur + RW'(1);
    end
  end

  // Position counters and output registers.
  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      col_reg       <= '0;
      row_reg       <= '0;
      data1_reg     <= '0;
      data2_reg     <= '0;
      data3_reg     <= '0;
      en_conv_reg   <= 1'b0;
      win_valid_reg <= 1'b0;
      eof_reg       <= 1'b0;
    end else begin
      // Flags are single-cycle: they drop on any idle cycle.
      en_conv_reg   <= bus.i_valid && !fill_rows;
      win_valid_reg <= bus.i_valid && !fill_rows && (32'(col_cur) >= 2);
      eof_reg       <= bus.i_valid && last_row && last_col;
      if (bus.i_valid) begin
        col_reg   <= col_next;
        row_reg   <= row_next;
        data1_reg <= lb_b[col_cur];
        data2_reg <= lb_a[col_cur];
        data3_reg <= bus.i_pixel;
      end
    end
  end

  // Line buffers are never cleared; stale contents only surface during the
  // two fill rows, where o_en_conv is held low.
  always_ff @(posedge clk) begin
    if (i_nrst && bus.i_valid) begin
      lb_b[col_cur] <= lb_a[col_cur];
      lb_a[col_cur] <= bus.i_pixel;
    end
  end

  assign bus.o_data1     = data1_reg;
  assign bus.o_data2     = data2_reg;
  assign bus.o_data3     = data3_reg;
  assign bus.o_en_conv   = en_conv_reg;
  assign bus.o_win_valid = win_valid_reg;
  assign bus.o_eof       = eof_reg;

endmodule
